// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: round-robin write arbiter plus burst/flush read FSM
// sharing a single fifo between N_REQ producers and one consumer.
module fifo_rr_scheduler #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int PTR_SIZE   = 5,
    parameter int BURST_LEN  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        fifo_wr_en,
    output logic [DATA_WIDTH-1:0]       fifo_data_in,
    input  logic                        fifo_full,
    input  logic [PTR_SIZE:0]           fifo_count,
    output logic                        fifo_re_en,
    input  logic [DATA_WIDTH-1:0]       fifo_data_out,
    input  logic                        fifo_empty,
    output logic                        out_valid,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_last,
    input  logic                        out_ready,
    input  logic                        flush,
    output logic                        flush_done,
    output logic                        busy
);

    localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW   = PTR_SIZE + 1;

    localparam logic [CW-1:0]   BURST_CNT = CW'(BURST_LEN);
    localparam logic [CW-1:0]   BURST_M1  = CW'(BURST_LEN - 1);
    localparam logic [RR_W-1:0] RR_LAST   = RR_W'(N_REQ - 1);

    if (DEPTH != (1 << PTR_SIZE)) begin : g_bad_depth
        $error("DEPTH must equal 2**PTR_SIZE");
    end
    if (BURST_LEN < 1 || BURST_LEN > DEPTH) begin : g_bad_burst
        $error("BURST_LEN must be in 1..DEPTH");
    end
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("N_REQ must be in 2..8");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_FLUSH
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   beat_q, beat_d;
    logic [CW-1:0]   flen_q, flen_d;
    logic            pend_q, pend_d;
    logic            done_q, done_d;
    logic [RR_W-1:0] rr_q, rr_d;

    logic [RR_W-1:0] gnt;
    logic            gnt_hit;
    logic [RR_W-1:0] scan;
    logic            wr_ok;
    logic            take;

    // Search from rr_q upward with explicit wrap at N_REQ for the first valid.
    always_comb begin
        gnt     = '0;
        gnt_hit = 1'b0;
        scan    = rr_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_hit && req_valid[scan]) begin
                gnt_hit = 1'b1;
                gnt     = scan;
            end
            scan = (scan == RR_LAST) ? '0 : scan + 1'b1;
        end
    end

    assign wr_ok      = !rst && gnt_hit && !fifo_full;
    assign fifo_wr_en = wr_ok;

    // Steer the granted requester's data and ready onto the fifo write side.
    always_comb begin
        req_ready    = '0;
        fifo_data_in = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt == RR_W'(i)) begin
                req_ready[i] = wr_ok;
                fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Pointer moves past the winner only on an accepted write.
    always_comb begin
        rr_d = rr_q;
        if (wr_ok) begin
            rr_d = (gnt == RR_LAST) ? '0 : gnt + 1'b1;
        end
    end

    // Read FSM next state and read-side outputs.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        flen_d     = flen_q;
        done_d     = 1'b0;
        take       = 1'b0;
        out_last   = 1'b0;
        out_valid  = !rst && (state_q != S_IDLE) && !fifo_empty;
        fifo_re_en = out_valid && out_ready;

        unique case (state_q)
            S_IDLE: begin
                if (pend_q && fifo_count != '0) begin
                    state_d = S_FLUSH;
                    flen_d  = fifo_count;
                    beat_d  = '0;
                    take    = 1'b1;
                end else if (pend_q) begin
                    done_d = 1'b1;
                    take   = 1'b1;
                end else if (fifo_count >= BURST_CNT) begin
                    state_d = S_BURST;
                    beat_d  = '0;
                end
            end
            S_BURST: begin
                out_last = !rst && (beat_q == BURST_M1);
            end
            S_FLUSH: begin
                out_last = !rst && (beat_q == flen_q - 1'b1);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fifo_re_en) begin
            beat_d = beat_q + 1'b1;
            if (out_last) begin
                state_d = S_IDLE;
                done_d  = (state_q == S_FLUSH);
            end
        end

        pend_d = flush || (pend_q && !take);
    end

    assign out_data   = fifo_data_out;
    assign flush_done = done_q && !rst;
    assign busy       = !rst && (state_q != S_IDLE);

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            flen_q  <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            flen_q  <= flen_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            rr_q    <= rr_d;
        end
    end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// tb_fifo_rr_scheduler: directed plus random stimulus against a
// queue-based reference model of the arbiter and burst/flush reader.
module tb_fifo_rr_scheduler;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 32;
    localparam int PS    = 5;
    localparam int BL    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_data_in;
    logic          fifo_full;
    logic [PS:0]   fifo_count;
    logic          fifo_re_en;
    logic [DW-1:0] fifo_data_out;
    logic          fifo_empty;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready = 1'b0;
    logic          flush = 1'b0;
    logic          flush_done;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_rr_scheduler #(
        .N_REQ(N), .DATA_WIDTH(DW), .DEPTH(DEPTH),
        .PTR_SIZE(PS), .BURST_LEN(BL)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready),
        .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
        .fifo_full(fifo_full), .fifo_count(fifo_count),
        .fifo_re_en(fifo_re_en), .fifo_data_out(fifo_data_out),
        .fifo_empty(fifo_empty),
        .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready),
        .flush(flush), .flush_done(flush_done), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    // Fall-through fifo: data_out shows the head combinationally.
    logic [DW-1:0] mem [0:DEPTH-1];
    logic [PS-1:0] wp, rp;
    logic [PS:0]   cnt;
    logic          f_wr, f_rd;

    assign fifo_full     = (cnt == 6'(DEPTH));
    assign fifo_empty    = (cnt == '0);
    assign fifo_count    = cnt;
    assign fifo_data_out = mem[rp];
    assign f_wr          = fifo_wr_en && !fifo_full;
    assign f_rd          = fifo_re_en && !fifo_empty;

    always @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (f_wr) begin
                mem[wp] <= fifo_data_in;
                wp      <= wp + 1'b1;
            end
            if (f_rd) rp <= rp + 1'b1;
            cnt <= cnt + {5'd0, f_wr} - {5'd0, f_rd};
        end
    end

    // Reference model: fifo contents, rotating pointer, beats still owed.
    logic [DW-1:0] m_q [$];
    int m_ptr  = 0;
    int m_rem  = 0;
    bit m_fl   = 1'b0;
    bit m_pend = 1'b0;
    bit m_done = 1'b0;

    task automatic check_eq(input string tag,
                            input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic [N-1:0]    rv,
                        input logic [N*DW-1:0] rd,
                        input logic            ordy,
                        input logic            fl,
                        input logic            r);
        int c_m, g, c;
        bit wr, ov, re, last, take, nd;
        logic [N-1:0]  e_rdy;
        logic [DW-1:0] e_dat;
        @(negedge clk);
        req_valid = rv;
        req_data  = rd;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        #1;
        c_m = m_q.size();
        g   = 0;
        wr  = 1'b0;
        if (!r) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (!wr && rv[c]) begin
                    wr = 1'b1;
                    g  = c;
                end
            end
            if (c_m == DEPTH) wr = 1'b0;
        end
        ov    = !r && m_rem > 0 && c_m > 0;
        re    = ov && ordy;
        last  = !r && m_rem == 1;
        e_rdy = wr ? N'(1 << g) : '0;
        e_dat = rd[g*DW +: DW];

        check_eq("req_ready", 32'(req_ready), 32'(e_rdy));
        check_eq("wr_en", 32'(fifo_wr_en), 32'(wr));
        if (wr) check_eq("wr_data", 32'(fifo_data_in), 32'(e_dat));
        check_eq("out_valid", 32'(out_valid), 32'(ov));
        if (ov) begin
            check_eq("out_data", 32'(out_data), 32'(m_q[0]));
            check_eq("out_last", 32'(out_last), 32'(last));
        end
        check_eq("re_en", 32'(fifo_re_en), 32'(re));
        check_eq("flush_done", 32'(flush_done), 32'(!r && m_done));
        check_eq("busy", 32'(busy), 32'(!r && m_rem > 0));

        if (r) begin
            m_q.delete();
            m_ptr  = 0;
            m_rem  = 0;
            m_pend = 1'b0;
            m_done = 1'b0;
        end else begin
            nd   = 1'b0;
            take = 1'b0;
            if (m_rem > 0) begin
                if (re) begin
                    m_rem--;
                    if (m_rem == 0 && m_fl) nd = 1'b1;
                end
            end else if (m_pend && c_m > 0) begin
                m_rem = c_m;
                m_fl  = 1'b1;
                take  = 1'b1;
            end else if (m_pend) begin
                nd   = 1'b1;
                take = 1'b1;
            end else if (c_m >= BL) begin
                m_rem = BL;
                m_fl  = 1'b0;
            end
            m_pend = fl || (m_pend && !take);
            if (re) void'(m_q.pop_front());
            if (wr) begin
                m_q.push_back(e_dat);
                m_ptr = (g + 1) % N;
            end
            m_done = nd;
        end
    endtask

    localparam logic [N*DW-1:0] D_ARB = 32'h13121110;
    localparam logic [13:0]     STALL = 14'b11111110001111;

    initial begin
        repeat (3) step('0, '0, 1'b0, 1'b0, 1'b1);

        // arbitration order with all requesters valid
        repeat (12) step(4'hF, D_ARB, 1'b1, 1'b0, 1'b0);

        // fill to full from requester 2 while the consumer stalls
        step('0, '0, 1'b0, 1'b0, 1'b1);
        repeat (36) step(4'b0100, D_ARB, 1'b0, 1'b0, 1'b0);
        repeat (2) step(4'b0111, D_ARB, 1'b0, 1'b0, 1'b0);
        step(4'b0111, D_ARB, 1'b1, 1'b0, 1'b0);
        repeat (3) step(4'b0111, D_ARB, 1'b0, 1'b0, 1'b0);

        // single burst 0x01..0x08
        step('0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++)
            step(4'b0001, 32'(i), 1'b1, 1'b0, 1'b0);
        repeat (12) step('0, '0, 1'b1, 1'b0, 1'b0);

        // consumer stall in mid-burst
        step('0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            step(4'b0001, 32'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 13; i >= 0; i--)
            step('0, '0, STALL[i], 1'b0, 1'b0);

        // flush of 5 entries with writes arriving during the flush
        step('0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            step(4'b0010, 32'(16'h3000 + (i << 8)), 1'b1, 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            step(4'b1000, 32'(24'h400000 + (i << 24)), 1'b1, 1'b0, 1'b0);
        repeat (6) step('0, '0, 1'b1, 1'b0, 1'b0);

        // flush with an empty fifo
        step('0, '0, 1'b1, 1'b0, 1'b1);
        step('0, '0, 1'b1, 1'b1, 1'b0);
        repeat (3) step('0, '0, 1'b1, 1'b0, 1'b0);

        // reset in mid-burst, then arbitration restarts at 0
        step('0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            step(4'b0100, 32'(24'h500000 + (i << 16)), 1'b0, 1'b0, 1'b0);
        repeat (4) step('0, '0, 1'b1, 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0, 1'b1);
        repeat (6) step(4'hF, D_ARB, 1'b1, 1'b0, 1'b0);

        // randomized traffic
        step('0, '0, 1'b0, 1'b0, 1'b1);
        repeat (3000) begin
            step(4'($urandom) & 4'($urandom),
                 $urandom,
                 ($urandom % 4) != 0,
                 ($urandom % 40) == 0,
                 ($urandom % 300) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
